// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end: scheduler state encoding and default frame geometry.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    PAD   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int IMG_WIDTH_DEF  = 512;
  localparam int IMG_HEIGHT_DEF = 512;
  localparam int PAD_LINES_DEF  = 2;
  localparam int NUM_LB_DEF     = 4;
  localparam int WIN_LINES_DEF  = 3;

endpackage

// File: rtl/lb_credit_counter.sv
// Free-line-buffer credit counter: starts full, saturates at the top and flags any overflow stickily.
module lb_credit_counter
  import sobel_pkg::*;
#(
  parameter int MAX = NUM_LB_DEF,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_credit,
  output logic         o_err
);

  localparam logic [W-1:0] FULL = W'(MAX);

  logic [W-1:0] r_credit;
  logic         r_err;

  // A simultaneous return and claim cancel out; a return into a full pool is a protocol error.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_credit <= FULL;
      r_err    <= 1'b0;
    end else if (i_inc && !i_dec) begin
      if (r_credit == FULL) begin
        r_err <= 1'b1;
      end else begin
        r_credit <= r_credit + W'(1);
      end
    end else if (i_dec && !i_inc && (r_credit != '0)) begin
      r_credit <= r_credit - W'(1);
    end
  end

  assign o_credit = r_credit;
  assign o_err    = r_err;

endmodule

// File: rtl/line_feed_scheduler.sv
// Feeds one frame of pixels into the line-buffer window controller, gated by line-buffer credit,
// then appends zero padding lines and signals frame completion once every output line is read.
module line_feed_scheduler
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int PAD_LINES  = PAD_LINES_DEF,
  parameter int NUM_LB     = NUM_LB_DEF,
  parameter int WIN_LINES  = WIN_LINES_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  output logic       o_busy,
  input  logic [7:0] i_s_data,
  input  logic       i_s_valid,
  output logic       o_s_ready,
  output logic [7:0] o_pix_data,
  output logic       o_pix_valid,
  input  logic       i_line_intr,
  output logic       o_frame_intr,
  output logic       o_err
);

  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int LINE_W = $clog2(IMG_HEIGHT + PAD_LINES + 1);
  localparam int CRED_W = $clog2(NUM_LB + 1);

  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] IMG_LINES  = LINE_W'(IMG_HEIGHT);
  localparam logic [LINE_W-1:0] LAST_IMG   = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [LINE_W-1:0] LAST_PAD   = LINE_W'(IMG_HEIGHT + PAD_LINES - 1);
  localparam logic [LINE_W-1:0] EXP_INTRS  = LINE_W'(IMG_HEIGHT + PAD_LINES - WIN_LINES + 1);

  state_t              r_state;
  state_t              w_next;
  logic [COL_W-1:0]    r_col;
  logic [LINE_W-1:0]   r_line;
  logic [LINE_W-1:0]   r_intr_cnt;
  logic [CRED_W-1:0]   w_credit;
  logic                w_col0;
  logic                w_gate_ok;
  logic                w_ready;
  logic                w_accept;
  logic                w_pad_emit;
  logic                w_emit;
  logic                w_line_start;
  logic                w_line_end;

  // Credit only gates the first pixel of a line; a return arriving that same cycle frees the slot.
  assign w_col0       = (r_col == '0);
  assign w_gate_ok    = !w_col0 || (w_credit != '0) || i_line_intr;
  assign w_ready      = (r_state == FEED) && w_gate_ok && (r_line < IMG_LINES);
  assign w_accept     = i_s_valid && w_ready;
  assign w_pad_emit   = (r_state == PAD) && w_gate_ok;
  assign w_emit       = w_accept || w_pad_emit;
  assign w_line_start = w_emit && w_col0;
  assign w_line_end   = w_emit && (r_col == LAST_COL);

  lb_credit_counter #(
    .MAX (NUM_LB),
    .W   (CRED_W)
  ) u_credit (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_inc    (i_line_intr),
    .i_dec    (w_line_start),
    .o_credit (w_credit),
    .o_err    (o_err)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    o_busy       = (r_state != IDLE);
    o_frame_intr = (r_state == DONE);
    o_s_ready    = w_ready;
    case (r_state)
      IDLE:  if (i_start) w_next = FEED;
      FEED:  if (w_line_end && (r_line == LAST_IMG)) w_next = (PAD_LINES > 0) ? PAD : DRAIN;
      PAD:   if (w_line_end && (r_line == LAST_PAD)) w_next = DRAIN;
      DRAIN: if (r_intr_cnt == EXP_INTRS) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Position counters restart on an accepted start; line-read returns only count inside a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col      <= '0;
      r_line     <= '0;
      r_intr_cnt <= '0;
    end else if ((r_state == IDLE) && i_start) begin
      r_col      <= '0;
      r_line     <= '0;
      r_intr_cnt <= '0;
    end else begin
      if (w_emit) begin
        r_col <= w_line_end ? '0 : r_col + COL_W'(1);
      end
      if (w_line_end) begin
        r_line <= r_line + LINE_W'(1);
      end
      if (i_line_intr && (r_state != IDLE)) begin
        r_intr_cnt <= r_intr_cnt + LINE_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
    end else begin
      o_pix_valid <= w_emit;
      o_pix_data  <= w_accept ? i_s_data : 8'h00;
    end
  end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Randomized bench for line_feed_scheduler on a 16x8 frame with two pad lines, checked against a
// pixel/line counting model of the credit-gated feed and a simple window-controller responder.
module tb_line_feed_scheduler;

  localparam int W   = 16;
  localparam int H   = 8;
  localparam int P   = 2;
  localparam int NLB = 4;
  localparam int WL  = 3;
  localparam int EXP = H + P - WL + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] sData = 8'h00;
  logic       sValid = 1'b0;
  logic       lineIntr = 1'b0;
  logic       busy;
  logic       sReady;
  logic [7:0] pixData;
  logic       pixValid;
  logic       frameIntr;
  logic       err;

  always #5 clk = ~clk;

  line_feed_scheduler #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PAD_LINES  (P),
    .NUM_LB     (NLB),
    .WIN_LINES  (WL)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .o_busy       (busy),
    .i_s_data     (sData),
    .i_s_valid    (sValid),
    .o_s_ready    (sReady),
    .o_pix_data   (pixData),
    .o_pix_valid  (pixValid),
    .i_line_intr  (lineIntr),
    .o_frame_intr (frameIntr),
    .o_err        (err)
  );

  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;
  bit mBusy, mErr, expValid, alwaysValid, startNoise, startReq, frameDone;
  logic [7:0] expData;
  int mCredit, pixIn, padOut, intrCnt, emitted, expFrameAt, flushReq, dLo, dHi;
  int dueQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic resetModel();
    mBusy = 0; mErr = 0; expValid = 0; expData = 8'h00; mCredit = NLB;
    pixIn = 0; padOut = 0; intrCnt = 0; emitted = 0; expFrameAt = -1;
    flushReq = 0; frameDone = 0; startReq = 0;
    dueQ.delete();
  endtask

  // The window-controller stand-in answers each completed output line after a random delay.
  task automatic applyStimulus();
    start = startReq || (startNoise && mBusy && ($urandom_range(0, 7) == 0));
    startReq = 0;
    if (flushReq > 0) begin
      lineIntr = 1'b1;
      flushReq--;
    end else if ((dueQ.size() > 0) && (dueQ[0] <= cyc)) begin
      lineIntr = 1'b1;
      void'(dueQ.pop_front());
    end else begin
      lineIntr = 1'b0;
    end
    sValid = alwaysValid ? 1'b1 : 1'($urandom_range(0, 1));
    sData  = 8'($urandom);
  endtask

  task automatic stepCycle();
    bit feedAct, padAct, gate, readyExp, acc, pe, ls;
    feedAct  = mBusy && (pixIn < H * W);
    padAct   = mBusy && (pixIn == H * W) && (padOut < P * W);
    gate     = (mCredit > 0) || lineIntr;
    readyExp = feedAct && (((pixIn % W) != 0) || gate);
    @(negedge clk);
    checkOutput("pix_valid", pixValid, expValid);
    if (expValid) checkOutput("pix_data", pixData, expData);
    checkOutput("s_ready", sReady, readyExp);
    checkOutput("busy", busy, mBusy);
    checkOutput("frame_intr", frameIntr, (cyc == expFrameAt));
    checkOutput("err", err, mErr);
    acc = readyExp && sValid;
    pe  = padAct && (((padOut % W) != 0) || gate);
    ls  = (acc && (pixIn % W == 0)) || (pe && (padOut % W == 0));
    expValid = acc || pe;
    expData  = acc ? sData : 8'h00;
    if (lineIntr && !ls) begin
      if (mCredit == NLB) mErr = 1; else mCredit++;
    end else if (ls && !lineIntr) begin
      mCredit--;
    end
    if (lineIntr && mBusy) begin
      intrCnt++;
      if (intrCnt == EXP) expFrameAt = cyc + 2;
    end
    if (acc || pe) begin
      emitted++;
      if ((emitted % W == 0) && (emitted / W >= WL)) dueQ.push_back(cyc + 1 + $urandom_range(dLo, dHi));
    end
    pixIn  += int'(acc);
    padOut += int'(pe);
    if (cyc == expFrameAt) begin
      mBusy = 0;
      frameDone = 1;
    end else if (start && !mBusy) begin
      mBusy = 1; pixIn = 0; padOut = 0; intrCnt = 0; emitted = 0; expFrameAt = -1;
    end
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  task automatic runFrame(input string tag, input int budget);
    int n;
    n = 0;
    startReq = 1;
    frameDone = 0;
    while (!frameDone && (n < budget)) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, frameDone, 1'b1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_ready"}, sReady, 0);
    checkOutput({tag, "_pvalid"}, pixValid, 0);
    checkOutput({tag, "_pdata"}, pixData, 0);
    checkOutput({tag, "_fintr"}, frameIntr, 0);
    checkOutput({tag, "_err"}, err, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    resetModel();
    alwaysValid = 1; startNoise = 0; dLo = 20; dHi = 20;
    #1 rst_n = 1'b0;
    #10 checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus();

    // Continuous stream: four lines pass, then the fifth waits for the first returned credit.
    runFrame("frame_a_done", 3000);
    idleCycles(3);
    flushReq = 2;
    idleCycles(4);
    flushReq = 1;
    idleCycles(3);
    checkOutput("err_sticky", err, 1'b1);

    // Gappy stream with stray start pulses while busy.
    alwaysValid = 0; startNoise = 1; dLo = 1; dHi = 40;
    runFrame("frame_b_done", 5000);
    startNoise = 0;
    idleCycles(3);
    flushReq = 2;
    idleCycles(4);

    // Reset in the middle of line 3, then a fresh frame.
    startReq = 1;
    n = 0;
    while ((pixIn < 3 * W + 5) && (n < 3000)) begin
      stepCycle();
      n++;
    end
    checkOutput("midframe_reached", (pixIn >= 3 * W + 5), 1'b1);
    rst_n = 1'b0;
    #2 checkAllZero("midreset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus();
    idleCycles(2);
    runFrame("frame_d_done", 5000);
    idleCycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
